// File: rtl/uart_tx_arbiter_if.sv
// Byte-request, UART-side and status signals of the UART TX arbiter.
// The master side drives requests and tx_ready. The slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int DEPTH = 8
);
    logic                     core_req;
    logic [7:0]               core_data;
    logic                     core_gnt;
    logic                     sid_req;
    logic [7:0]               sid_data;
    logic                     sid_last;
    logic                     sid_gnt;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     tx_ready;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     lock;
    logic                     abort;

    modport master (
        output core_req, core_data, sid_req, sid_data, sid_last, tx_ready,
        input  core_gnt, sid_gnt, tx_valid, tx_data, fifo_count, lock, abort
    );

    modport slave (
        input  core_req, core_data, sid_req, sid_data, sid_last, tx_ready,
        output core_gnt, sid_gnt, tx_valid, tx_data, fifo_count, lock, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Arbitrates core and sID byte writes into a circular TX FIFO that feeds the UART.
// An sID burst holds a lock that shuts out the core. An idle timeout drops the lock.
module uart_tx_arbiter #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] OPEN     = 1'b0;
    localparam logic [0:0] SID_LOCK = 1'b1;

    logic [0:0]    state;
    logic          prio_sid;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          can_push;
    logic          core_gnt;
    logic          sid_gnt;
    logic          push;
    logic          pop;
    logic          timeout_hit;
    logic [7:0]    push_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        core_gnt = 1'b0;
        sid_gnt  = 1'b0;
        can_push = !rst && (count < CW'(DEPTH));
        if (can_push) begin
            if (state == SID_LOCK) begin
                sid_gnt = bus.sid_req;
            end else if (bus.core_req && bus.sid_req) begin
                sid_gnt  = prio_sid;
                core_gnt = !prio_sid;
            end else begin
                core_gnt = bus.core_req;
                sid_gnt  = bus.sid_req;
            end
        end
        push        = core_gnt || sid_gnt;
        push_data   = sid_gnt ? bus.sid_data : bus.core_data;
        pop         = (count != '0) && bus.tx_ready;
        // Abort is high in the idle cycle whose closing edge brings the count to TIMEOUT.
        timeout_hit = !rst && (state == SID_LOCK) && !sid_gnt
                      && (idle_cnt == IW'(TIMEOUT - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OPEN;
            prio_sid <= 1'b0;
            idle_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (state == OPEN) begin
                if (sid_gnt && !bus.sid_last) state <= SID_LOCK;
            end else if ((sid_gnt && bus.sid_last) || timeout_hit) begin
                state <= OPEN;
            end

            if (sid_gnt || (state == OPEN)) idle_cnt <= '0;
            else                            idle_cnt <= idle_cnt + IW'(1);

            if (core_gnt)     prio_sid <= 1'b1;
            else if (sid_gnt) prio_sid <= 1'b0;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: storage is cleared on reset so the head reads 8'h00 until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign bus.core_gnt   = core_gnt;
    assign bus.sid_gnt    = sid_gnt;
    assign bus.tx_valid   = (count != '0);
    assign bus.tx_data    = mem[rd_ptr];
    assign bus.fifo_count = count;
    assign bus.lock       = (state == SID_LOCK);
    assign bus.abort      = timeout_hit;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a per-cycle queue model plus directed scenarios.
// The scenarios check order, round-robin, full, timeout, wrap and mid-burst reset.
module tb_uart_tx_arbiter;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic tog = 1'b0;
    logic tog_en = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_ready = tog_en ? tog : ready;
    always @(posedge clk) if (tog_en) tog <= ~tog;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, a lock flag, an idle-cycle count and a fairness bit.
    logic [7:0] m_q[$];
    bit  m_lock, m_sid_turn, m_fresh, model_on;
    int  m_idle;
    bit  e_core, e_sid, e_abort, space;
    logic [7:0] seen[$];
    int  lock_core_gnts, max_count;

    always @(negedge clk) begin
        space   = m_q.size() < DEPTH;
        e_core  = 1'b0;
        e_sid   = 1'b0;
        if (!rst && space) begin
            if (m_lock) e_sid = bus.sid_req;
            else if (bus.core_req && bus.sid_req) begin
                e_sid  = m_sid_turn;
                e_core = !m_sid_turn;
            end else begin
                e_core = bus.core_req;
                e_sid  = bus.sid_req;
            end
        end
        e_abort = !rst && m_lock && !e_sid && (m_idle + 1 == TIMEOUT);

        if (model_on) begin
            check("core_gnt",   int'(bus.core_gnt),   int'(e_core));
            check("sid_gnt",    int'(bus.sid_gnt),    int'(e_sid));
            check("abort",      int'(bus.abort),      int'(e_abort));
            check("lock",       int'(bus.lock),       int'(m_lock));
            check("tx_valid",   int'(bus.tx_valid),   int'(m_q.size() != 0));
            check("fifo_count", int'(bus.fifo_count), m_q.size());
            if (m_q.size() != 0) check("tx_data", int'(bus.tx_data), int'(m_q[0]));
            else if (m_fresh)    check("tx_data_fresh", int'(bus.tx_data), 0);
            if (!rst && bus.tx_valid && bus.tx_ready) seen.push_back(bus.tx_data);
            if (bus.lock && bus.core_gnt) lock_core_gnts++;
            if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
        end

        if (rst) begin
            m_q.delete();
            m_lock = 0; m_sid_turn = 0; m_fresh = 1; m_idle = 0;
            model_on = 1;
        end else if (model_on) begin
            if (m_q.size() != 0 && bus.tx_ready) void'(m_q.pop_front());
            if (e_core) begin m_q.push_back(bus.core_data); m_fresh = 0; m_sid_turn = 1; end
            if (e_sid)  begin m_q.push_back(bus.sid_data);  m_fresh = 0; m_sid_turn = 0; end
            if (m_lock) begin
                if (e_sid) begin
                    m_idle = 0;
                    if (bus.sid_last) m_lock = 0;
                end else if (e_abort) begin
                    m_lock = 0;
                    m_idle = 0;
                end else m_idle++;
            end else if (e_sid && !bus.sid_last) begin
                m_lock = 1;
                m_idle = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.core_req = 0; bus.core_data = 0;
        bus.sid_req = 0;  bus.sid_data = 0; bus.sid_last = 0;
        ready = 0; tog_en = 0;
        tick(); tick();
        rst = 1'b0;
        seen.delete();
        lock_core_gnts = 0;
        max_count = 0;
        @(negedge clk);
        check("rst_tx_valid",   int'(bus.tx_valid),   0);
        check("rst_fifo_count", int'(bus.fifo_count), 0);
        check("rst_lock",       int'(bus.lock),       0);
        check("rst_abort",      int'(bus.abort),      0);
        check("rst_tx_data",    int'(bus.tx_data),    0);
        tick();
    endtask

    task automatic send_core(input logic [7:0] b);
        bit g = 0;
        bus.core_req = 1; bus.core_data = b;
        for (int i = 0; i < 60 && !g; i++) begin
            @(negedge clk);
            g = bus.core_gnt;
            tick();
        end
        if (!g) check("core_gnt_wait", 0, 1);
    endtask

    task automatic send_sid(input logic [7:0] b, input bit last);
        bit g = 0;
        bus.sid_req = 1; bus.sid_data = b; bus.sid_last = last;
        for (int i = 0; i < 60 && !g; i++) begin
            @(negedge clk);
            g = bus.sid_gnt;
            tick();
        end
        if (!g) check("sid_gnt_wait", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        bus.core_req = 0; bus.sid_req = 0;
        tog_en = 0; ready = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (bus.fifo_count == 0);
            tick();
        end
        if (!done) check("drain_wait", 0, 1);
    endtask

    task automatic compare_seen(input string nm, input logic [7:0] exp[$]);
        check({nm, "_len"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            check(nm, int'(seen[i]), int'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst[$];
        logic [7:0] exp[$];

        // Burst order: sID wins first, core waits out the whole lock.
        do_reset();
        ready = 1;
        burst = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};
        send_sid(burst[0], 1'b0);
        bus.core_req = 1; bus.core_data = 8'h41;
        for (int i = 1; i < 10; i++) send_sid(burst[i], i == 9);
        bus.sid_req = 0;
        send_core(8'h41);
        drain();
        check("burst_core_in_lock", lock_core_gnts, 0);
        exp = burst;
        exp.push_back(8'h41);
        compare_seen("burst_order", exp);

        // Round-robin with single-byte sID bursts.
        do_reset();
        ready = 1;
        bus.core_req = 1; bus.core_data = 8'h41;
        bus.sid_req = 1;  bus.sid_data = 8'h32; bus.sid_last = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_grant", bus.core_gnt ? 1 : (bus.sid_gnt ? 2 : 0), (k % 2 == 0) ? 1 : 2);
            tick();
        end
        drain();
        compare_seen("rr_order", '{8'h41, 8'h32, 8'h41, 8'h32});

        // Full FIFO: ninth byte waits, and is taken the cycle after a pop, not during it.
        do_reset();
        for (int i = 1; i <= 8; i++) send_core(8'(i));
        bus.core_data = 8'h09;
        @(negedge clk);
        check("full_count", int'(bus.fifo_count), 8);
        check("full_hold_gnt", int'(bus.core_gnt), 0);
        tick();
        ready = 1;
        @(negedge clk);
        check("full_pop_cycle_gnt", int'(bus.core_gnt), 0);
        check("full_pop_head", int'(bus.tx_data), 1);
        tick();
        ready = 0;
        @(negedge clk);
        check("full_after_pop_gnt", int'(bus.core_gnt), 1);
        tick();
        drain();
        compare_seen("full_order", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09});

        // Timeout: 16 idle cycles in lock produce one abort, then core is granted.
        do_reset();
        ready = 1;
        send_sid(8'h32, 1'b0);
        bus.sid_req = 0;
        bus.core_req = 1; bus.core_data = 8'h41;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check("to_abort", int'(bus.abort), int'(k == TIMEOUT));
            check("to_lock_held", int'(bus.lock), 1);
            tick();
        end
        @(negedge clk);
        check("to_lock_dropped", int'(bus.lock), 0);
        check("to_abort_once", int'(bus.abort), 0);
        check("to_core_gnt", int'(bus.core_gnt), 1);
        tick();
        drain();
        compare_seen("to_order", '{8'h32, 8'h41});

        // Wrap with simultaneous push/pop: UART ready toggles every cycle.
        do_reset();
        tog_en = 1;
        exp.delete();
        for (int i = 0; i < 20; i++) begin
            send_core(8'(i));
            exp.push_back(8'(i));
        end
        drain();
        check("wrap_max_count", max_count, 8);
        compare_seen("wrap_order", exp);

        // Reset in mid-burst with three bytes queued.
        do_reset();
        for (int i = 0; i < 5; i++) send_sid(8'h50 + 8'(i), 1'b0);
        bus.sid_req = 0;
        ready = 1;
        tick(); tick();
        ready = 0;
        @(negedge clk);
        check("mid_count_before", int'(bus.fifo_count), 3);
        check("mid_lock_before", int'(bus.lock), 1);
        tick();
        rst = 1;
        bus.sid_req = 1; bus.sid_data = 8'h77; bus.sid_last = 0;
        @(negedge clk);
        check("mid_rst_sid_gnt", int'(bus.sid_gnt), 0);
        check("mid_rst_abort", int'(bus.abort), 0);
        tick();
        rst = 0;
        bus.sid_req = 0;
        @(negedge clk);
        check("mid_count_after", int'(bus.fifo_count), 0);
        check("mid_valid_after", int'(bus.tx_valid), 0);
        check("mid_lock_after", int'(bus.lock), 0);
        check("mid_abort_after", int'(bus.abort), 0);
        check("mid_data_after", int'(bus.tx_data), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DEPTH, default 8: TX FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Parameter TIMEOUT, default 16: idle cycles allowed inside an sID burst before the burst lock is dropped.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 core_req_i  in  1  core store to the UART address requests one byte.
REQ-006 core_data_i  in  8  core byte.
REQ-007 core_gnt_o  out  1  core byte accepted this cycle (combinational).
REQ-008 sid_req_i  in  1  sID sequencer requests one byte.
REQ-009 sid_data_i  in  8  sID byte.
REQ-010 sid_last_i  in  1  current sID byte is the final byte of the burst.
REQ-011 sid_gnt_o  out  1  sID byte accepted this cycle (combinational).
REQ-012 tx_valid_o  out  1  FIFO head valid toward the UART.
REQ-013 tx_data_o  out  8  FIFO head byte.
REQ-014 tx_ready_i  in  1  UART accepts the head byte this cycle.
REQ-015 fifo_count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 lock_o  out  1  sID burst lock held.
REQ-017 abort_o  out  1  one-cycle pulse when the burst lock is dropped by timeout.

Function
REQ-018 The FSM SHALL have 2 states, OPEN and SID_LOCK; reset state is OPEN; lock_o is 1 only in SID_LOCK.
REQ-019 Push is allowed only when fifo_count_o < DEPTH; there is no push-through when full, even if a pop occurs in the same cycle.
REQ-020 In OPEN, a single requester SHALL be granted when push is allowed.
REQ-021 In OPEN, when both requesters are active, the one not granted most recently SHALL win; after reset, core SHALL win.
REQ-022 At most one grant SHALL be asserted per cycle; a grant pushes that requester's data into the FIFO in the same cycle.
REQ-023 OPEN -> SID_LOCK when sid_gnt_o=1 and sid_last_i=0.
REQ-024 An sID grant with sid_last_i=1 in OPEN SHALL stay in OPEN, making it a single-byte burst.
REQ-025 In SID_LOCK, core_gnt_o SHALL be 0; sid_gnt_o = sid_req_i and push allowed.
REQ-026 SID_LOCK -> OPEN on sid_gnt_o=1 with sid_last_i=1; the next arbitration then favours core.
REQ-027 An idle counter SHALL clear on entry to SID_LOCK and on every sid_gnt_o.
REQ-028 The idle counter SHALL increment on each SID_LOCK cycle without sid_gnt_o, including cycles stalled by a full FIFO.
REQ-029 When the idle counter reaches TIMEOUT, the FSM SHALL go to OPEN and assert abort_o for exactly that transition cycle.
REQ-030 The FIFO SHALL be circular, with rd/wr pointers wrapping modulo DEPTH.
REQ-031 tx_valid_o = (count != 0); tx_data_o = entry at the read pointer, driven combinationally from storage.
REQ-032 A pop SHALL occur when tx_valid_o and tx_ready_i are both 1; tx_ready_i SHALL be ignored when the FIFO is empty.
REQ-033 Simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-034 A byte pushed into an empty FIFO SHALL appear on tx_data_o, with tx_valid_o=1, in the next cycle (1-cycle latency).
REQ-035 Bytes SHALL leave in exact acceptance order; no byte is ever dropped or duplicated.

Reset
REQ-036 While rst=1 at a clock edge: FSM=OPEN; pointers, count and idle counter=0; round-robin favours core.
REQ-037 Reset outputs SHALL be: tx_valid_o=0, fifo_count_o=0, lock_o=0, abort_o=0.
REQ-038 Grant outputs SHALL be 0 while rst=1.
REQ-039 tx_data_o SHALL read 8'h00 after reset until the first push.
REQ-040 Reset mid-burst or with a non-empty FIFO SHALL discard all contents and the lock, with no abort_o pulse.

Verification
REQ-041 Order: sID sends 10-byte burst 32 30 32 33 33 31 30 36 35 35 (last on byte 10), core requests 41 throughout, tx_ready_i=1 -> core_gnt_o=0 during the burst (lock_o=1) and UART sees 32 30 32 33 33 31 30 36 35 35 41 when sID wins first.
REQ-042 Round-robin: both request continuously, single-byte sID bursts (sid_last_i=1), core 41 / sID 32 -> grants alternate core, sID, core...; output 41 32 41 32.
REQ-043 Full: tx_ready_i=0, core pushes 9 bytes 01..09 -> 8 grants, count=8, 9th held with core_gnt_o=0. Then one pop with the 9th request still active -> 09 accepted on the following cycle, not the pop cycle.
REQ-044 Timeout: sID grants byte 32 with sid_last_i=0, then sid_req_i=0 for 16 cycles -> abort_o pulses once on cycle 16, lock_o falls, and a pending core byte is granted the next cycle.
REQ-045 Wrap and simultaneous push/pop: 20 core bytes 00..13 with tx_ready_i toggling every cycle -> pointers wrap, count never exceeds 8, output equals input order.
REQ-046 Reset: rst asserted after 5 bytes of a burst with count=3 -> next cycle count=0, tx_valid_o=0, lock_o=0, abort_o=0.
